// File: rtl/conv_dispatcher_if.sv
`default_nettype none
// ============================================================================
// conv_dispatcher_if
// Pixel stream, kernel load, ALU handshake and output pixel bundle.
// Revision: 1.0
// ============================================================================
interface conv_dispatcher_if;
    logic         kern_wr;
    logic [7:0]   kern_data;
    logic [1:0]   mode;
    logic         pix_valid;
    logic         pix_ready;
    logic [7:0]   pix_data;
    logic [199:0] alu_matriz_a;
    logic [199:0] alu_matriz_b;
    logic [1:0]   alu_seletor;
    logic         alu_start;
    logic         alu_done;
    logic [199:0] alu_result;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         busy;
    logic         err;

    modport master (
        input  kern_wr, kern_data, mode, pix_valid, pix_data,
               alu_done, alu_result, out_ready,
        output pix_ready, alu_matriz_a, alu_matriz_b, alu_seletor,
               alu_start, out_valid, out_data, busy, err
    );

    modport slave (
        output kern_wr, kern_data, mode, pix_valid, pix_data,
               alu_done, alu_result, out_ready,
        input  pix_ready, alu_matriz_a, alu_matriz_b, alu_seletor,
               alu_start, out_valid, out_data, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/conv_dispatcher.sv
`default_nettype none
// ============================================================================
// conv_dispatcher
// Builds 5x5 windows, drives the ALU start/done handshake, emits one pixel.
// Revision: 1.0
// ============================================================================
module conv_dispatcher #(
    parameter int TIMEOUT = 255
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    conv_dispatcher_if.master bus
);
    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    localparam logic [7:0] C_TCNT_LAST = 8'(TIMEOUT - 1);

    state_t       state;
    state_t       state_nxt;
    logic [4:0]   cnt;
    logic [4:0]   kptr;
    logic [7:0]   tcnt;
    logic         pending;
    logic [199:0] window;
    logic [199:0] kernel;
    logic [1:0]   seletor;
    logic         start;
    logic [7:0]   result;
    logic         err_pulse;

    logic         pix_fire;
    logic         last_byte;
    logic         timeout_hit;
    logic         idle;
    logic [7:0]   win_idx;
    logic [7:0]   kern_idx;
    logic         unused_result_bits;

    assign pix_fire    = (state == S_LOAD) && bus.pix_valid;
    assign last_byte   = (cnt == 5'd24);
    assign timeout_hit = (tcnt == C_TCNT_LAST);
    assign idle        = (state == S_LOAD) && (cnt == 5'd0);
    assign win_idx     = {cnt, 3'b000};
    assign kern_idx    = {kptr, 3'b000};
    assign unused_result_bits = ^{bus.alu_result[199:24], bus.alu_result[15:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Done has priority over timeout in WAIT; RELEASE holds until done is seen low.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:    if (pix_fire && last_byte) state_nxt = S_WAIT;
            S_WAIT:    if (bus.alu_done || timeout_hit) state_nxt = S_RELEASE;
            S_RELEASE: if (!bus.alu_done) state_nxt = pending ? S_OUTPUT : S_LOAD;
            S_OUTPUT:  if (bus.out_ready) state_nxt = S_LOAD;
            default:   state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 5'd0;
            kptr      <= 5'd0;
            tcnt      <= 8'd0;
            pending   <= 1'b0;
            window    <= '0;
            kernel    <= '0;
            seletor   <= 2'b00;
            start     <= 1'b0;
            result    <= 8'd0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;

            if (pix_fire) begin
                window[win_idx +: 8] <= bus.pix_data;
                if (cnt == 5'd0) begin
                    seletor <= bus.mode;
                end
                if (last_byte) begin
                    cnt   <= 5'd0;
                    start <= 1'b1;
                end else begin
                    cnt <= cnt + 5'd1;
                end
            end

            if (bus.kern_wr && idle) begin
                kernel[kern_idx +: 8] <= bus.kern_data;
                kptr <= (kptr == 5'd24) ? 5'd0 : kptr + 5'd1;
            end

            if (state == S_WAIT) begin
                if (bus.alu_done) begin
                    result  <= seletor[1] ? bus.alu_result[23:16] : bus.alu_result[7:0];
                    start   <= 1'b0;
                    tcnt    <= 8'd0;
                    pending <= 1'b1;
                end else if (timeout_hit) begin
                    start     <= 1'b0;
                    err_pulse <= 1'b1;
                    tcnt      <= 8'd0;
                    pending   <= 1'b0;
                end else begin
                    tcnt <= tcnt + 8'd1;
                end
            end
        end
    end

    assign bus.pix_ready    = (state == S_LOAD);
    assign bus.busy         = !idle;
    assign bus.out_valid    = (state == S_OUTPUT);
    assign bus.out_data     = result;
    assign bus.alu_matriz_a = window;
    assign bus.alu_matriz_b = kernel;
    assign bus.alu_seletor  = seletor;
    assign bus.alu_start    = start;
    assign bus.err          = err_pulse;
endmodule
`default_nettype wire
